// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;
    localparam int KP_KEYS = KP_ROWS * KP_COLS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_EVAL
    } kp_state_t;

    // Lowest index wins when several keys appear in the same commit.
    function automatic logic [3:0] lowest_set_index(input logic [KP_KEYS-1:0] vec);
        logic [3:0] idx;
        idx = '0;
        for (int i = KP_KEYS - 1; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchroniser; resets to all-ones so idle (pulled-up) columns read as released.
module keypad_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan_debounce.sv
// Row-scans a 4x4 active-low keypad, debounces whole frames and emits press/release events.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int ROW_CYCLES      = 25000,
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic               clk_25MHz,
    input  logic               rst_n,
    input  logic [KP_COLS-1:0] key_col,
    output logic [KP_ROWS-1:0] key_row,
    output logic [KP_KEYS-1:0] key_state,
    output logic               key_any,
    output logic [3:0]         key_code,
    output logic               key_press,
    output logic               key_release
);

    localparam int CNT_W = $clog2(ROW_CYCLES);
    localparam int DB_W  = $clog2(DEBOUNCE_FRAMES + 1);

    kp_state_t          r_state;
    kp_state_t          w_next_state;
    logic [1:0]         r_row;
    logic [1:0]         w_next_row;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [KP_ROWS-1:0] r_key_row;
    logic [KP_ROWS-1:0] w_next_key_row;
    logic [KP_KEYS-1:0] r_frame;
    logic [KP_KEYS-1:0] r_cand;
    logic [DB_W-1:0]    r_stable;
    logic [DB_W-1:0]    w_next_stable;
    logic [KP_KEYS-1:0] r_key_state;
    logic [3:0]         r_key_code;
    logic               r_press;
    logic               r_release;
    logic [KP_COLS-1:0] w_sync_col;
    logic               w_drive_done;
    logic               w_frame_match;
    logic               w_commit;
    logic [KP_KEYS-1:0] w_new_keys;

    keypad_sync2 #(.WIDTH(KP_COLS)) u_sync (
        .clk   (clk_25MHz),
        .rst_n (rst_n),
        .i_d   (key_col),
        .o_q   (w_sync_col)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_row   = r_row;
        w_drive_done = (r_cycle_cnt == CNT_W'(ROW_CYCLES - 1));
        case (r_state)
            S_IDLE:   w_next_state = S_DRIVE;
            S_DRIVE:  if (w_drive_done) w_next_state = S_SAMPLE;
            S_SAMPLE: begin
                if (r_row == 2'd3) begin
                    w_next_state = S_EVAL;
                end else begin
                    w_next_state = S_DRIVE;
                    w_next_row   = r_row + 2'd1;
                end
            end
            S_EVAL: begin
                w_next_state = S_DRIVE;
                w_next_row   = 2'd0;
            end
            default:  w_next_state = S_IDLE;
        endcase
        // Rows are only pulled low while driving; the register keeps key_row glitch-free.
        w_next_key_row = (w_next_state == S_DRIVE) ? ~(KP_ROWS'(1) << w_next_row) : '1;
    end

    always_comb begin
        w_frame_match = (r_frame == r_cand);
        w_next_stable = '0;
        if (w_frame_match) begin
            w_next_stable = (r_stable == DB_W'(DEBOUNCE_FRAMES)) ? r_stable : r_stable + DB_W'(1);
        end
        w_commit   = (w_next_stable == DB_W'(DEBOUNCE_FRAMES)) && (r_cand != r_key_state);
        w_new_keys = r_cand & ~r_key_state;
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_row       <= 2'd0;
            r_cycle_cnt <= '0;
            r_key_row   <= '1;
            r_frame     <= '0;
            r_cand      <= '0;
            r_stable    <= '0;
            r_key_state <= '0;
            r_key_code  <= '0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_row     <= w_next_row;
            r_key_row <= w_next_key_row;
            r_press   <= 1'b0;
            r_release <= 1'b0;

            if (r_state == S_DRIVE && !w_drive_done) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            else                                      r_cycle_cnt <= '0;

            if (r_state == S_SAMPLE) r_frame[{r_row, 2'b00} +: KP_COLS] <= ~w_sync_col;

            if (r_state == S_EVAL) begin
                if (!w_frame_match) r_cand <= r_frame;
                r_stable <= w_next_stable;
                if (w_commit) begin
                    r_key_state <= r_cand;
                    if (|w_new_keys) begin
                        r_press    <= 1'b1;
                        r_key_code <= lowest_set_index(w_new_keys);
                    end
                    if (r_cand == '0) r_release <= 1'b1;
                end
            end
        end
    end

    assign key_row     = r_key_row;
    assign key_state   = r_key_state;
    assign key_any     = |r_key_state;
    assign key_code    = r_key_code;
    assign key_press   = r_press;
    assign key_release = r_release;

endmodule

// File: doc/keypad_scan_debounce.md
# keypad_scan_debounce

Scans a 4x4 active-low matrix keypad, synchronises and debounces the column returns, and publishes a debounced 16-key state. It also publishes one-cycle press/release events with a key code. It sits directly upstream of the 240x160 LCD image-switch display: `key_any` drives that block's `key_switch` input as a clean, debounced level. The display block does its own rising-edge detection.

## Interface
Parameters:
- `ROW_CYCLES`, default 25000: clocks each row is driven before sampling (1 ms at 25 MHz); minimum 2.
- `DEBOUNCE_FRAMES`, default 5: consecutive identical frames required before a new state is committed; minimum 1.

Ports:
- `clk_25MHz`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `key_col`  in  4  column returns; low = pressed key on the driven row; asynchronous to the clock.
- `key_row`  out  4  row drives, one-cold; registered.
- `key_state`  out  16  debounced map; bit = row*4+col, 1 = pressed.
- `key_any`  out  1  OR of `key_state`; feeds the display's `key_switch`.
- `key_code`  out  4  index of the most recent press event; holds its value across releases.
- `key_press`  out  1  one-cycle pulse on a commit that adds at least one pressed key.
- `key_release`  out  1  one-cycle pulse on a commit to all-released from non-zero.

## Operation
- **Reset values.** `key_row`=4'b1111, `key_state`=0, `key_any`=0, `key_code`=0, `key_press`=0, `key_release`=0. Internal state: FSM=S_IDLE, row index 0, candidate=0, stable count 0. Assertion mid-scan clears everything immediately, including `key_row`.
- **Synchronisation.** `key_col` passes through two flops before any use.
- **FSM states:**
  - S_IDLE: one cycle, then S_DRIVE with row 0.
  - S_DRIVE: `key_row`=~(1<<row). Counts `ROW_CYCLES` cycles, then goes to S_SAMPLE.
  - S_SAMPLE: one cycle. Captures ~sync_col into frame bits [row*4+3:row*4].
    - If row<3: row+1, back to S_DRIVE.
    - Else: S_EVAL.
  - S_EVAL: one cycle. Runs the debounce step, sets row to 0, goes to S_DRIVE.
- **Debounce step (S_EVAL):**
  - If frame≠candidate: candidate←frame, count←0.
  - Else: count←min(count+1, `DEBOUNCE_FRAMES`).
  - Commit when the new count equals `DEBOUNCE_FRAMES` and candidate≠`key_state`. On commit, `key_state`←candidate.
- **Events.** Evaluated against the pre-commit `key_state`:
  - `key_press`=1 if (cand & ~old)≠0. `key_code`←index of the lowest set bit of (cand & ~old).
  - `key_release`=1 if cand==0 and old≠0.
  - A commit that only removes some keys while others stay held pulses neither output.
- **Multiple keys.** No anti-ghosting; raw matrix states are reported. Simultaneous new presses report the lowest index.

## Timing
- Frame length = 4·(`ROW_CYCLES`+1)+1 cycles. With defaults this is 100005 cycles, about 4 ms.
- `key_state`, `key_any`, `key_code`, `key_press` and `key_release` all update on the clock edge ending S_EVAL, i.e. registered, visible in the cycle after S_EVAL. Pulses last exactly one cycle.
- Press latency, from the first stable frame that shows the key to the pulse: `DEBOUNCE_FRAMES` further frames. The candidate is first loaded in one frame, then needs `DEBOUNCE_FRAMES` matching frames.
- Bounce shorter than `DEBOUNCE_FRAMES` frames never commits.
- A key held indefinitely produces exactly one press pulse; count saturation prevents re-commit.
- A column change during S_DRIVE has no effect until S_SAMPLE, plus 2 cycles of synchroniser delay.

## Structure
- Package `keypad_pkg`:
  - FSM enum: S_IDLE, S_DRIVE, S_SAMPLE, S_EVAL.
  - Constants KP_ROWS=4, KP_COLS=4, KP_KEYS=16.
  - A lowest-set-bit-index function.
- Sub-module `keypad_sync2`: parameterised-width two-flop synchroniser, reset to all-ones (idle columns).
- Counter widths are $clog2-derived from the parameters.

## Test plan
All scenarios use `ROW_CYCLES`=4, `DEBOUNCE_FRAMES`=3, giving a 21-cycle frame.

- **Reset and row sequence.** Hold `rst_n` low, then release. Required: `key_row`=1111 during reset. After release: one cycle of 1111, then 1110 for 4 cycles, 1101, 1011, 0111, repeating. All outputs stay 0 with `key_col`=1111.
- **Single press.** Model key 6 (row 1, col 2) pulling col2 low while row1 is driven, held 10 frames. Required: exactly one `key_press` pulse, `key_code`=6, `key_state`=16'h0040, `key_any`=1. The pulse arrives 3 frames after the first frame that samples the key.
- **Bounce rejection.** Toggle key 6 each frame for 8 frames, then release. Required: no pulses, `key_state` stays 0.
- **Release.** Release key 6 after it has been committed. Required: one `key_release` pulse 3 frames later, `key_state`=0, `key_any`=0, `key_code` still 6.
- **Multi-key.**
  - Press keys 9 and 3 together. Required: one press pulse, `key_code`=3, `key_state`=16'h0208.
  - Then add key 15 while holding both. Required: a second pulse, `key_code`=15.
  - Then release only key 3. Required: no pulse, `key_state`=16'h8200.
- **Reset mid-scan.** Assert `rst_n` mid-frame while key 6 is committed. Required: `key_row`=1111 and all outputs 0 immediately. After release with the key still held: a fresh press pulse 3 frames later.
